// File: rtl/gf2_div_pkg.sv
// Shared types and defaults for the sequential GF(2)[x] polynomial divider.
package gf2_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N     = 521;
    localparam int DEFAULT_CNT_W = $clog2(2 * DEFAULT_N);

endpackage

// File: rtl/gf2_div_step.sv
// One shift-and-XOR long-division iteration over GF(2): eliminates bit cnt of r.
module gf2_div_step
    import gf2_div_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int CNT_W = $clog2(2 * N)
) (
    input  logic [2*N-1:0]   r,
    input  logic [N:0]       d,
    input  logic [CNT_W-1:0] cnt,
    output logic [2*N-1:0]   r_next,
    output logic             q_bit
);

    logic [CNT_W-1:0] shift;
    logic [2*N-1:0]   d_wide;

    assign shift  = cnt - CNT_W'(N);
    assign d_wide = {{(N - 1){1'b0}}, d};

    // Gating on d[N] means a non-monic divisor never subtracts, leaving r untouched.
    assign q_bit  = r[cnt] & d[N];
    assign r_next = q_bit ? (r ^ (d_wide << shift)) : r;

endmodule

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2)[x] divider: quotient and remainder of a 2N-bit dividend by a degree-N divisor.
// Optional divisor validation is enabled with `define GF2_DIV_DIVISOR_CHECK_EN.
module gf2_poly_divider
    import gf2_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N:0]     divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           error
);

    localparam int CNT_W = $clog2(2 * N);

    state_t           state;
    logic [2*N-1:0]   r;
    logic [N:0]       d;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   r_next;
    logic             q_bit;
    logic [CNT_W-1:0] q_pos;

    gf2_div_step #(.N(N), .CNT_W(CNT_W)) u_step (
        .r      (r),
        .d      (d),
        .cnt    (cnt),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    assign q_pos = cnt - CNT_W'(N);

`ifndef GF2_DIV_DIVISOR_CHECK_EN
    assign error = 1'b0;
`endif

    // NOTE: every register here is assigned with <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            r         <= '0;
            d         <= '0;
            cnt       <= '0;
`ifdef GF2_DIV_DIVISOR_CHECK_EN
            error     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r         <= dividend;
                        d         <= divisor;
                        quotient  <= '0;
                        remainder <= '0;
                        cnt       <= CNT_W'(2 * N - 1);
`ifdef GF2_DIV_DIVISOR_CHECK_EN
                        error     <= ~divisor[N];
                        if (!divisor[N]) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state     <= RUN;
                        busy      <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r        <= r_next;
                    quotient <= quotient | (N'(q_bit) << q_pos);
                    cnt      <= cnt - 1'b1;
                    if (cnt == CNT_W'(N)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remainder <= r_next[N-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gf2_poly_divider.md
# gf2_poly_divider

Sequential GF(2)[x] polynomial divider/reducer: the return path for the Karatsuba carry-less multipliers. It takes a 2N-bit carry-less product and a degree-N modulus polynomial and returns quotient and remainder, each N bits. It uses shift-and-XOR long division, one dividend bit per clock. It sits downstream of the multiplier in field-arithmetic datapaths (e.g. GF(2^521) reduction).

## Interface
- N, 521, field degree; dividend 2N bits, divisor N+1 bits, quotient and remainder N bits each
- clk  input  1  clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only while busy=0
- dividend  input  2N  carry-less product; bit 0 = x^0
- divisor  input  N+1  modulus polynomial; bit N is the leading term
- busy  output  1  division in progress
- done  output  1  one-cycle pulse: quotient/remainder/error valid
- quotient  output  N  floor(dividend / divisor) over GF(2)
- remainder  output  N  dividend mod divisor over GF(2)
- error  output  1  divisor rejected (only with the check macro; otherwise constant 0)

## Operation
- FSM states:
  - IDLE: busy=0. On start=1, load r ← dividend and d ← divisor, clear q, set cnt ← 2N-1, go to RUN.
  - RUN: busy=1. Each cycle: if r[cnt]=1 then r ← r ^ (d << (cnt-N)) and q[cnt-N] ← 1. Then cnt ← cnt-1. At the cycle that processes cnt==N, go to DONE.
  - DONE: busy=0, done=1. Go to IDLE, or straight to RUN if start=1 in this cycle.
- remainder = r[N-1:0] latched at the RUN→DONE edge. quotient = q. Both hold until the next accepted start.
- Arithmetic is pure XOR with no carries. The working register r is 2N bits and d is N+1 bits.
- start while busy=1 is ignored. It is not queued.
- Dividend and divisor are captured at the accept edge, so later input changes have no effect.
- Reset values: busy=0, done=0, error=0, quotient=0, remainder=0, state=IDLE.
- rst asserted mid-RUN aborts within one edge. All outputs return to reset values and no done is produced.

## Timing
- Start accepted at edge E0. RUN spans edges E1..EN, with N iterations for bits 2N-1 down to N.
- done is high in the cycle after edge EN, which is N cycles after the accept edge.
- Throughput: one division per N+1 cycles when start is held high (accepted in IDLE or DONE).
- Outputs are registered. The combinational path covers only the 2N-bit XOR and bit select.

## Configuration
- GF2_DIV_DIVISOR_CHECK_EN defined:
  - At accept, if divisor[N]=0, the FSM goes directly to DONE instead of RUN.
  - done and error assert together one cycle after accept; quotient=0 and remainder=0.
  - error holds until the next accepted start.
- Macro undefined:
  - No check; error is tied to 0.
  - A divisor with divisor[N]=0 runs the normal N iterations. It never triggers an XOR at the leading position, so the result is quotient=0 and remainder=dividend[N-1:0], which is not a valid reduction. Callers must supply a monic degree-N divisor.

## Structure
- Package gf2_div_pkg:
  - state enum: IDLE, RUN, DONE
  - default N
  - counter width localparam: $clog2(2N)
- Sub-module gf2_div_step: combinational single iteration.
  - Inputs: r, d, cnt.
  - Outputs: next r and the quotient bit.
  - Instantiated once inside the FSM.

## Test plan
- N=8, divisor 0x11B, dividend 0x3F7E (0x53·0xCA carry-less), start one cycle → done 8 cycles later, quotient=0x3D, remainder=0x01, error=0.
- N=8, divisor 0x11B, dividend 0x0000 → quotient=0x00, remainder=0x00. Dividend 0x011B → quotient=0x01, remainder=0x00.
- N=8, start held high across DONE with two dividends (0x3F7E, then 0x00FF) → two done pulses 9 cycles apart. Second result: quotient=0x00, remainder=0xFF.
- N=8, start pulsed at cycle 3 of RUN with different data → ignored; first result unchanged, only one done.
- rst asserted at cycle 4 of RUN → next cycle busy=0, quotient=0, remainder=0; no done pulse. A fresh start afterwards completes normally.
- With GF2_DIV_DIVISOR_CHECK_EN, N=8, divisor 0x0FF → done and error high one cycle after accept, quotient=0, remainder=0. The same stimulus without the macro → done after 8 cycles, error=0, quotient=0x00, remainder=dividend[7:0].
